// File: rtl/adder_pkg.sv
// Shared helpers for the segmented, pipelined adder.
package adder_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_SEGS  = 2;

    // Width of one segment; every pipeline stage adds exactly this many bits.
    function automatic int seg_w(input int width, input int segs);
        return width / segs;
    endfunction

    // Legal shapes: at least one segment, no empty segments, equal segment widths.
    function automatic bit params_ok(input int width, input int segs);
        if (segs < 1 || segs > width) begin
            return 1'b0;
        end
        return (width % segs) == 0;
    endfunction

endpackage

// File: rtl/adder_pipe_stage.sv
// One segment of the pipelined adder: adds its SEG_W-bit slice plus the carry
// coming from the previous stage, and registers the whole slot (valid, carry,
// partial sum, operands) so the next stage sees a consistent snapshot.
module adder_pipe_stage
    import adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SEGS  = DEF_SEGS,
    parameter int IDX   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_advance,
    input  logic             i_valid,
    input  logic             i_carry,
    input  logic [WIDTH-1:0] i_sum,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_valid,
    output logic             o_carry,
    output logic [WIDTH-1:0] o_sum,
    output logic [WIDTH-1:0] o_a,
    output logic [WIDTH-1:0] o_b
);

    localparam int SEG_W = seg_w(WIDTH, SEGS);
    localparam int LO    = IDX * SEG_W;

    // Bits of sum below this segment arrive already computed; bits above are
    // still zero and get filled in by later stages. Operand bits below this
    // segment are dead after this point and are trimmed by synthesis.
    typedef struct packed {
        logic             valid;
        logic             carry;
        logic [WIDTH-1:0] sum;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } adder_stage_t;

    adder_stage_t     r_stage;
    adder_stage_t     w_next;
    logic [SEG_W:0]   w_seg;

    // Segment add and assembly of the next register contents.
    always_comb begin
        // NOTE: every field gets a full assignment before the segment slice is
        // overwritten, so no path leaves a bit unassigned and no latch appears.
        w_seg        = {1'b0, i_a[LO +: SEG_W]} + {1'b0, i_b[LO +: SEG_W]}
                     + {{SEG_W{1'b0}}, i_carry};
        w_next.valid = i_valid;
        w_next.carry = w_seg[SEG_W];
        w_next.sum   = i_sum;
        w_next.sum[LO +: SEG_W] = w_seg[SEG_W-1:0];
        w_next.a     = i_a;
        w_next.b     = i_b;
    end

    // Pipeline register: shifts on advance, holds on stall.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: data fields are reset along with valid because sum/cout/ovf
        // are observable outputs that must read zero straight out of reset.
        if (!rst_n) begin
            r_stage <= '0;
        end else if (i_advance) begin
            // NOTE: non-blocking so every stage samples its neighbour's old value.
            r_stage <= w_next;
        end
    end

    assign o_valid = r_stage.valid;
    assign o_carry = r_stage.carry;
    assign o_sum   = r_stage.sum;
    assign o_a     = r_stage.a;
    assign o_b     = r_stage.b;

endmodule

// File: rtl/adder_pipe.sv
// Pipelined WIDTH-bit adder split into SEGS segments, one per stage, with the
// carry rippling through registers and a valid/ready handshake on both sides.
module adder_pipe
    import adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SEGS  = DEF_SEGS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    if (!params_ok(WIDTH, SEGS)) begin : g_param_check
        $error("adder_pipe: WIDTH must be a multiple of SEGS and SEGS must be in 1..WIDTH");
    end

    // Index 0 is the input side, index SEGS the last stage register.
    logic             w_valid [SEGS+1];
    logic             w_carry [SEGS+1];
    logic [WIDTH-1:0] w_sum   [SEGS+1];
    logic [WIDTH-1:0] w_a     [SEGS+1];
    logic [WIDTH-1:0] w_b     [SEGS+1];
    logic             w_advance;
    logic             w_msb_carry_in;
    logic             w_unused;

    // The whole pipe moves as one: it shifts unless a valid result is waiting
    // on a downstream that is not ready. Bubbles are deliberately not squeezed.
    assign w_advance = !w_valid[SEGS] || out_ready;
    assign in_ready  = w_advance;

    assign w_valid[0] = in_valid;
    assign w_carry[0] = cin;
    assign w_sum[0]   = '0;
    assign w_a[0]     = in1;
    assign w_b[0]     = in2;

    for (genvar k = 0; k < SEGS; k++) begin : g_stage
        adder_pipe_stage #(
            .WIDTH (WIDTH),
            .SEGS  (SEGS),
            .IDX   (k)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_advance (w_advance),
            .i_valid   (w_valid[k]),
            .i_carry   (w_carry[k]),
            .i_sum     (w_sum[k]),
            .i_a       (w_a[k]),
            .i_b       (w_b[k]),
            .o_valid   (w_valid[k+1]),
            .o_carry   (w_carry[k+1]),
            .o_sum     (w_sum[k+1]),
            .o_a       (w_a[k+1]),
            .o_b       (w_b[k+1])
        );
    end

    // Carry into the MSB is recovered from the MSB sum bit and its operands;
    // signed overflow is that carry disagreeing with the carry out.
    assign w_msb_carry_in = w_sum[SEGS][WIDTH-1] ^ w_a[SEGS][WIDTH-1] ^ w_b[SEGS][WIDTH-1];

    assign out_valid = w_valid[SEGS];
    assign sum       = w_sum[SEGS];
    assign cout      = w_carry[SEGS];
    assign ovf       = w_carry[SEGS] ^ w_msb_carry_in;

    // Only the operand MSBs are needed once the last segment has been added.
    assign w_unused = ^{w_a[SEGS], w_b[SEGS]};

endmodule
